// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the three-master Wishbone bus arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam int         NUM_M    = 3;
    localparam logic [1:0] NO_OWNER = 2'd3;
    localparam int         TMO_W    = 10;

    // Index reached by stepping k places forward from base, wrapping over the masters.
    function automatic logic [1:0] rr_step(input logic [1:0] base, input int unsigned k);
        int unsigned w_sum;
        w_sum = int'(base) + k;
        return 2'(w_sum % NUM_M);
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin requester selection: searches last+1, last+2, last+3 (mod 3).
module wb_arb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [1:0]       last,
    output logic [1:0]       idx,
    output logic             valid
);

    logic [1:0] w_cand;

    // Walk the search order backwards so the earliest requester is the last one written.
    always_comb begin
        idx    = NO_OWNER;
        valid  = 1'b0;
        w_cand = 2'd0;
        for (int k = NUM_M; k >= 1; k--) begin
            w_cand = rr_step(last, k);
            if (req[w_cand]) begin
                idx   = w_cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arb.sv
// Three-master to one-slave Wishbone arbiter with locked bursts and a slave
// response timeout that turns a hung cycle into an error to the owner.
module wb_bus_arb
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int AW          = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [2:0]          m_cyc_i,
    input  logic [2:0]          m_stb_i,
    input  logic [2:0]          m_we_i,
    input  logic [3*AW-1:0]     m_adr_i,
    input  logic [95:0]         m_dat_i,
    input  logic [11:0]         m_sel_i,
    output logic [31:0]         m_dat_o,
    output logic [2:0]          m_ack_o,
    output logic [2:0]          m_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    input  logic [31:0]         s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic [1:0]          gnt_o
);

    arb_state_e       r_state, w_state_nxt;
    logic [1:0]       r_owner, w_owner_nxt;
    logic [1:0]       r_last, w_last_nxt;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;

    logic             w_owned;
    logic             w_pick_vld;
    logic [1:0]       w_pick_idx;
    logic             w_own_cyc, w_own_stb, w_own_we;
    logic [AW-1:0]    w_own_adr;
    logic [31:0]      w_own_dat;
    logic [3:0]       w_own_sel;
    logic             w_tmo_hit;

    wb_arb_rr_pick u_pick (
        .req   (m_cyc_i),
        .last  (r_last),
        .idx   (w_pick_idx),
        .valid (w_pick_vld)
    );

    assign w_owned = (r_state == ST_OWNED);

    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        for (int n = 0; n < NUM_M; n++) begin
            if (w_owned && r_owner == 2'(n)) begin
                w_own_cyc = m_cyc_i[n];
                w_own_stb = m_stb_i[n];
                w_own_we  = m_we_i[n];
                w_own_adr = m_adr_i[n*AW +: AW];
                w_own_dat = m_dat_i[n*32 +: 32];
                w_own_sel = m_sel_i[n*4 +: 4];
            end
        end
    end

    // Reset kills the in-flight cycle immediately so nothing is acknowledged.
    assign s_cyc_o = w_own_cyc & ~wb_rst_i;
    assign s_stb_o = w_own_stb & ~wb_rst_i;
    assign s_we_o  = w_own_we;
    assign s_adr_o = w_own_adr;
    assign s_dat_o = w_own_dat;
    assign s_sel_o = w_own_sel;
    assign m_dat_o = s_dat_i;
    assign gnt_o   = w_owned ? r_owner : NO_OWNER;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) & s_stb_o & ~s_ack_i & ~s_err_i;

    // Slave responses are passed through untouched, ack and err together if both arrive.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int n = 0; n < NUM_M; n++) begin
            if (r_owner == 2'(n)) begin
                m_ack_o[n] = s_stb_o & s_ack_i;
                m_err_o[n] = s_stb_o & (s_err_i | w_tmo_hit);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_tmo_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = w_pick_idx;
                end
            end
            ST_OWNED: begin
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                    w_owner_nxt = NO_OWNER;
                end else if (s_stb_o && !s_ack_i && !s_err_i && !w_tmo_hit) begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = NO_OWNER;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_owner   <= NO_OWNER;
            r_last    <= 2'd2;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_tmo_cnt <= w_tmo_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bus_arb.sv
// Randomised and directed bench for wb_bus_arb against a cycle-level behavioural model.
module tb_wb_bus_arb;

    localparam int AW  = 32;
    localparam int TMO = 4;

    localparam int K_GNT    = 0;
    localparam int K_ERR    = 1;
    localparam int K_ACKDAT = 2;
    localparam int K_ACKERR = 3;
    localparam int K_SCYC   = 4;
    localparam int K_SUP    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    cyc, stb, we;
    logic [AW-1:0] adr  [3];
    logic [31:0]   wdat [3];
    logic [3:0]    sel  [3];
    logic [31:0]   s_dat;
    logic          s_ack, s_err;

    logic [31:0]   m_dat_o;
    logic [2:0]    m_ack_o, m_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic [3:0]    s_sel_o;
    logic [1:0]    gnt_o;

    always #5 clk = ~clk;

    wb_bus_arb #(.TIMEOUT_CYC(TMO), .AW(AW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_cyc_i  (cyc),
        .m_stb_i  (stb),
        .m_we_i   (we),
        .m_adr_i  ({adr[2], adr[1], adr[0]}),
        .m_dat_i  ({wdat[2], wdat[1], wdat[0]}),
        .m_sel_i  ({sel[2], sel[1], sel[0]}),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err),
        .gnt_o    (gnt_o)
    );

    // Behavioural model: who owns the bus, who went last, how long the slave has stalled.
    bit m_init  = 1'b0;
    bit m_owned = 1'b0;
    int m_owner = 0;
    int m_last  = 2;
    int m_tmo   = 0;

    int checks = 0;
    int errors = 0;

    logic        lit_en   = 1'b0;
    int          lit_kind = 0;
    logic [63:0] lit_exp  = '0;
    logic [63:0] lit_sup  = '0;
    string       lit_name = "";

    function automatic int rr_first(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++)
            if (r[(last + k) % 3]) return (last + k) % 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_owned <= 1'b0;
            m_last  <= 2;
            m_tmo   <= 0;
            m_owner <= 0;
        end else if (m_init) begin
            if (!m_owned) begin
                if (cyc != 3'b000) begin
                    m_owned <= 1'b1;
                    m_owner <= rr_first(cyc, m_last);
                    m_tmo   <= 0;
                end
            end else if (!cyc[m_owner]) begin
                m_owned <= 1'b0;
                m_last  <= m_owner;
                m_tmo   <= 0;
            end else if (stb[m_owner] && !s_ack && !s_err) begin
                m_tmo <= (m_tmo == TMO - 1) ? 0 : m_tmo + 1;
            end else begin
                m_tmo <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: model check every cycle plus any posted literal expectation.
    always @(negedge clk) begin : cmp
        int          w;
        bit          live, hit;
        logic [2:0]  e_ack, e_err;
        logic [63:0] act;
        if (m_init) begin
            w     = m_owned ? m_owner : 0;
            live  = m_owned && !rst;
            hit   = live && stb[w] && !s_ack && !s_err && (m_tmo == TMO - 1);
            e_ack = (live && stb[w] && s_ack) ? 3'(1 << w) : 3'b000;
            e_err = (live && stb[w] && (s_err || hit)) ? 3'(1 << w) : 3'b000;
            chk("gnt",   64'(gnt_o),   m_owned ? 64'(m_owner) : 64'd3);
            chk("s_cyc", 64'(s_cyc_o), 64'(live && cyc[w]));
            chk("s_stb", 64'(s_stb_o), 64'(live && stb[w]));
            chk("s_we",  64'(s_we_o),  64'(m_owned && we[w]));
            chk("s_adr", 64'(s_adr_o), m_owned ? 64'(adr[w]) : 64'd0);
            chk("s_dat", 64'(s_dat_o), m_owned ? 64'(wdat[w]) : 64'd0);
            chk("s_sel", 64'(s_sel_o), m_owned ? 64'(sel[w]) : 64'd0);
            chk("m_ack", 64'(m_ack_o), 64'(e_ack));
            chk("m_err", 64'(m_err_o), 64'(e_err));
            chk("m_dat", 64'(m_dat_o), 64'(s_dat));
            if (lit_en) begin
                case (lit_kind)
                    K_GNT:    act = 64'(gnt_o);
                    K_ERR:    act = 64'(m_err_o);
                    K_ACKDAT: act = {29'd0, m_ack_o, m_dat_o};
                    K_ACKERR: act = {58'd0, m_ack_o, m_err_o};
                    K_SCYC:   act = {62'd0, s_cyc_o, s_stb_o};
                    default:  act = lit_sup;
                endcase
                chk(lit_name, act, lit_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic post(input int kind, input logic [63:0] exp, input string name);
        lit_en   = 1'b1;
        lit_kind = kind;
        lit_exp  = exp;
        lit_name = name;
    endtask

    task automatic post_sup(input logic [63:0] act, input logic [63:0] exp, input string name);
        lit_sup = act;
        post(K_SUP, exp, name);
    endtask

    task automatic go_idle();
        tick();
        rst = 1'b0; cyc = '0; stb = '0; s_ack = 1'b0; s_err = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int seq [8] = '{3, 0, 3, 1, 3, 2, 3, 0};
        int cnt, bad0, k;
        bit got;

        rst = 1'b1; cyc = '0; stb = '0; we = '0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        for (int n = 0; n < 3; n++) begin
            adr[n]  = AW'(32'h1000 * (n + 1));
            wdat[n] = 32'hA000_0000 + 32'(n);
            sel[n]  = 4'(n + 1);
        end
        tick();
        post(K_GNT, 64'd3, "reset_gnt");
        tick();
        post(K_SCYC, 64'd0, "reset_s_cyc_stb");

        // All three request continuously; each drops cyc the cycle it is granted.
        tick();
        rst = 1'b0; cyc = 3'b111;
        post(K_GNT, 64'(seq[0]), "rr_order");
        for (int i = 1; i < 8; i++) begin
            tick();
            cyc = 3'b111 & ~(3'b001 << gnt_o);
            post(K_GNT, 64'(seq[i]), "rr_order");
        end
        go_idle();

        // Master 1 locked 4-beat burst while master 0 waits.
        tick(); cyc = 3'b010;
        tick(); cyc = 3'b011; stb = 3'b010; we = 3'b010;
        cnt = 0; bad0 = 0; k = 0;
        while (cnt < 4 && k < 24) begin
            s_ack = (k % 2 == 1);
            @(negedge clk); #1;
            if (m_ack_o[1]) cnt++;
            if (m_ack_o[0]) bad0++;
            tick();
            k++;
        end
        cyc = 3'b001; stb = 3'b000; s_ack = 1'b0; we = 3'b000;
        post_sup(64'(cnt), 64'd4, "burst_ack_count");
        tick();
        post_sup(64'(bad0), 64'd0, "burst_m0_ack_quiet");
        got = 1'b0;
        for (int j = 0; j < 6 && !got; j++) begin
            tick();
            if (gnt_o == 2'd0) got = 1'b1;
        end
        post_sup(64'(got), 64'd1, "m0_granted_after_burst");
        go_idle();

        // Slave never answers: error on every 4th stalled strobe.
        tick(); cyc = 3'b001;
        tick(); stb = 3'b001;
        post(K_ERR, 64'd0, "timeout_err");
        for (int i = 1; i < 8; i++) begin
            tick();
            post(K_ERR, (i == 3 || i == 7) ? 64'd1 : 64'd0, "timeout_err");
        end
        go_idle();

        // Read of DEADBEEF by master 2.
        tick(); cyc = 3'b100;
        tick(); stb = 3'b100;
        tick(); s_dat = 32'hDEADBEEF; s_ack = 1'b1;
        post(K_ACKDAT, {29'd0, 3'b100, 32'hDEADBEEF}, "read_ack_data");
        tick(); s_ack = 1'b0;
        go_idle();

        // Reset in the middle of a master 1 burst while the slave responds.
        tick(); cyc = 3'b010;
        tick(); stb = 3'b010;
        tick(); cyc = 3'b011;
        tick(); rst = 1'b1; s_ack = 1'b1; s_err = 1'b1;
        post(K_ACKERR, 64'd0, "reset_no_response");
        tick(); rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        post(K_GNT, 64'd3, "reset_gnt_idle");
        tick();
        post(K_GNT, 64'd0, "reset_m0_first");
        go_idle();

        // Random traffic with sticky cycle requests.
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(5) == 0) cyc[n] = ~cyc[n];
                adr[n]  = AW'($urandom);
                wdat[n] = $urandom;
                sel[n]  = 4'($urandom);
            end
            stb   = 3'($urandom);
            we    = 3'($urandom);
            s_dat = $urandom;
            s_ack = ($urandom_range(2) == 0);
            s_err = ($urandom_range(9) == 0);
            rst   = ($urandom_range(149) == 0);
        end
        go_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_bus_arb.md
WB_BUS_ARB -- requirements
Module: wb_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: slave cycles without ack/err before forced error (range 2..1023).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port m_cyc_i  in  3  per-master cycle request (bit n = master n).
REQ-006 SHALL have port m_stb_i  in  3  per-master strobe.
REQ-007 SHALL have port m_we_i  in  3  per-master write enable.
REQ-008 SHALL have port m_adr_i  in  3*AW  per-master address; master n at [n*AW +: AW].
REQ-009 SHALL have port m_dat_i  in  96  per-master write data; master n at [n*32 +: 32].
REQ-010 SHALL have port m_sel_i  in  12  per-master byte select; master n at [n*4 +: 4].
REQ-011 SHALL have port m_dat_o  out  32  read data broadcast to all masters.
REQ-012 SHALL have port m_ack_o  out  3  per-master acknowledge.
REQ-013 SHALL have port m_err_o  out  3  per-master error.
REQ-014 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
REQ-015 SHALL have ports s_adr_o (AW), s_dat_o (32), s_sel_o (4)  out  slave address, write data, byte select.
REQ-016 SHALL have port s_dat_i  in  32  slave read data.
REQ-017 SHALL have ports s_ack_i, s_err_i  in  1 each  slave acknowledge and error.
REQ-018 SHALL have port gnt_o  out  2  current owner index; 2'd3 = no owner.

Function
REQ-019 SHALL implement an FSM with states IDLE and OWNED, plus registers owner[1:0], last[1:0] and tmo_cnt[9:0].
REQ-020 From IDLE with any m_cyc_i bit set, SHALL enter OWNED at the next edge, with owner set to the first requester in round-robin order last+1, last+2, last+3 (mod 3).
REQ-021 In IDLE, s_cyc_o and s_stb_o SHALL be 0, m_ack_o and m_err_o SHALL be 0, and gnt_o SHALL be 3.
REQ-022 In OWNED, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o SHALL be combinational muxes of the owner's inputs (zero added latency); gnt_o SHALL equal owner.
REQ-023 m_ack_o[owner] SHALL equal s_ack_i & m_stb_i[owner], and m_err_o[owner] SHALL equal (s_err_i | tmo_hit) & m_stb_i[owner]; non-owner bits SHALL be 0.
REQ-024 m_dat_o SHALL equal s_dat_i unconditionally.
REQ-025 OWNED SHALL persist while m_cyc_i[owner]=1, holding across multiple stb beats (locked bursts).
REQ-026 When m_cyc_i[owner]=0 in OWNED, the block SHALL set last<=owner and return to IDLE; s_cyc_o SHALL drop combinationally that cycle, and a minimum 1-cycle IDLE gap SHALL precede any new grant.
REQ-027 Requests arriving mid-ownership SHALL wait; no preemption.
REQ-028 tmo_cnt SHALL increment each OWNED cycle with s_stb_o=1 and s_ack_i=s_err_i=0, and SHALL clear on ack, err, stb low, or IDLE.
REQ-029 tmo_hit SHALL be (tmo_cnt == TIMEOUT_CYC-1) & s_stb_o & ~s_ack_i & ~s_err_i; it SHALL produce a one-cycle error to the owner and clear tmo_cnt.
REQ-030 If s_ack_i and s_err_i are both asserted, both SHALL pass to the owner unchanged; the block SHALL perform no arbitration of slave responses.

Reset
REQ-031 When wb_rst_i=1 at an edge, the block SHALL set state=IDLE, owner=3, last=2 (so master 0 wins first), tmo_cnt=0; all outputs SHALL then be at their IDLE values.
REQ-032 Reset asserted during OWNED SHALL abandon the transfer with no ack or err generated; the reset value SHALL be held for as long as wb_rst_i=1.

Structure
REQ-033 Package wb_arb_pkg SHALL hold the state enum, NUM_M=3, NO_OWNER=2'd3, and the TMO_W=10 constant.
REQ-034 A sub-module wb_arb_rr_pick (combinational: req[2:0], last[1:0] -> idx[1:0], valid) SHALL implement the round-robin selection; all other logic SHALL be in wb_bus_arb.

Verification
REQ-035 After reset, assert m_cyc_i=3'b111 -> grants SHALL occur in order 0,1,2,0, each separated by one IDLE cycle, with gnt_o tracking the owner.
REQ-036 Master 1 4-beat locked burst (cyc held, slave acks every 2nd cycle) while master 0 requests -> exactly 4 acks SHALL reach m_ack_o[1], m_ack_o[0]=0 throughout, and master 0 SHALL be granted after cyc1 drops.
REQ-037 TIMEOUT_CYC=4, slave never acks -> m_err_o[owner]=1 SHALL occur on the 4th stb cycle for exactly 1 cycle, and other err bits SHALL remain 0.
REQ-038 Slave read of 32'hDEADBEEF to master 2 -> m_dat_o=32'hDEADBEEF and m_ack_o=3'b100 SHALL occur in the same cycle as s_ack_i.
REQ-039 wb_rst_i pulsed mid-burst of master 1 -> no ack or err SHALL be issued, gnt_o=3 next cycle, and master 0 SHALL be granted first after reset.
